// File: rtl/win_checker.sv
// win_checker: Connect-4 win detector, one board anchor evaluated per cycle.
// Optional macro WIN_MASK_EN drives win_mask with the cells of the winning line.
module win_checker (
    input  logic        clk,
    input  logic        reset,
    input  logic [41:0] red_player,
    input  logic [41:0] yellow_player,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [1:0]  winner,
    output logic        check,
    output logic [41:0] win_mask
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [41:0] LINE_H  = 42'h00000F;
    localparam logic [41:0] LINE_V  = 42'h204081;
    localparam logic [41:0] LINE_DR = 42'h1010101;
    localparam logic [41:0] LINE_DL = 42'h041041;
    localparam logic [41:0] FULL    = {42{1'b1}};

    state_e      state_q, state_d;
    logic [41:0] red_q, red_d;
    logic [41:0] yel_q, yel_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  winner_q, winner_d;
    logic        check_q, check_d;

    logic [5:0]  idx;
    logic        h_ok, v_ok, dr_ok, dl_ok;
    logic [41:0] m_h, m_v, m_dr, m_dl;
    logic [7:0]  hits;
    logic        hit, last;

    // Anchor index = row*7 + col, built from shifts so no multiplier is needed
    always_comb begin
        idx   = {row_q, 3'b000} - {3'b000, row_q} + {3'b000, col_q};
        h_ok  = (col_q <= 3'd3);
        v_ok  = (row_q <= 3'd2);
        dr_ok = h_ok && v_ok;
        dl_ok = (col_q >= 3'd3) && v_ok;
        m_h   = LINE_H  << idx;
        m_v   = LINE_V  << idx;
        m_dr  = LINE_DR << idx;
        m_dl  = LINE_DL << idx;
        last  = (row_q == 3'd5) && (col_q == 3'd6);
    end

    // Bits 0..3 red H/V/DR/DL, bits 4..7 yellow; lower bit has priority
    always_comb begin
        hits[0] = h_ok  && ((red_q & m_h)  == m_h);
        hits[1] = v_ok  && ((red_q & m_v)  == m_v);
        hits[2] = dr_ok && ((red_q & m_dr) == m_dr);
        hits[3] = dl_ok && ((red_q & m_dl) == m_dl);
        hits[4] = h_ok  && ((yel_q & m_h)  == m_h);
        hits[5] = v_ok  && ((yel_q & m_v)  == m_v);
        hits[6] = dr_ok && ((yel_q & m_dr) == m_dr);
        hits[7] = dl_ok && ((yel_q & m_dl) == m_dl);
        hit     = |hits;
    end

    always_comb begin
        state_d  = state_q;
        red_d    = red_q;
        yel_d    = yel_q;
        row_d    = row_q;
        col_d    = col_q;
        done_d   = 1'b0;
        winner_d = winner_q;
        check_d  = check_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    red_d   = red_player;
                    yel_d   = yellow_player;
                    row_d   = 3'd0;
                    col_d   = 3'd0;
                end
            end
            SCAN: begin
                if (hit) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    winner_d = (|hits[3:0]) ? 2'b01 : 2'b10;
                    check_d  = 1'b1;
                end else if (last) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    winner_d = ((red_q | yel_q) == FULL) ? 2'b11 : 2'b00;
                    check_d  = ((red_q | yel_q) == FULL);
                end else if (col_q == 3'd6) begin
                    col_d = 3'd0;
                    row_d = row_q + 3'd1;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            red_q    <= '0;
            yel_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            winner_q <= 2'b00;
            check_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            red_q    <= red_d;
            yel_q    <= yel_d;
            row_q    <= row_d;
            col_q    <= col_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            winner_q <= winner_d;
            check_q  <= check_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign winner = winner_q;
    assign check  = check_q;

`ifdef WIN_MASK_EN
    logic [7:0]  first_hit;
    logic [41:0] mask_q, mask_d;

    always_comb begin
        first_hit = hits & (~hits + 8'd1);
        mask_d    = mask_q;
        if (state_q == SCAN && (hit || last)) begin
            mask_d = ({42{first_hit[0] | first_hit[4]}} & m_h)
                   | ({42{first_hit[1] | first_hit[5]}} & m_v)
                   | ({42{first_hit[2] | first_hit[6]}} & m_dr)
                   | ({42{first_hit[3] | first_hit[7]}} & m_dl);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign win_mask = mask_q;
`else
    assign win_mask = '0;
`endif

endmodule

// File: tb/tb_win_checker.sv
// tb_win_checker: directed and randomized checks of win_checker
// against a board-geometry reference model.
module tb_win_checker;

    logic        clk;
    logic        reset;
    logic [41:0] red;
    logic [41:0] yellow;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic        check_o;
    logic [41:0] win_mask;

    int n_checks;
    int n_errors;

    win_checker dut (
        .clk           (clk),
        .reset         (reset),
        .red_player    (red),
        .yellow_player (yellow),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .winner        (winner),
        .check         (check_o),
        .win_mask      (win_mask)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [41:0] rand42();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[41:0];
    endfunction

    function automatic logic [41:0] mask_exp(input logic [41:0] m);
`ifdef WIN_MASK_EN
        return m;
`else
        return (m & 42'h0);
`endif
    endfunction

    // Reference: walk anchors in (row, col) order, red before yellow,
    // directions H, V, DR, DL, stepping in board coordinates.
    function automatic void model(input logic [41:0] r, input logic [41:0] y,
                                  output int lat, output logic [1:0] w,
                                  output logic [41:0] m);
        int drs [4] = '{0, 1, 1, 1};
        int dcs [4] = '{1, 0, 1, -1};
        logic [41:0] b, mm;
        int row, col, rr, cc;
        bit found, ok;
        found = 0;
        lat   = 42;
        w     = 2'b00;
        m     = '0;
        for (int a = 0; a < 42; a++) begin
            row = a / 7;
            col = a % 7;
            for (int p = 0; p < 2; p++) begin
                b = (p == 0) ? r : y;
                for (int d = 0; d < 4; d++) begin
                    ok = 1;
                    mm = '0;
                    for (int i = 0; i < 4; i++) begin
                        rr = row + i * drs[d];
                        cc = col + i * dcs[d];
                        if (rr > 5 || cc < 0 || cc > 6) ok = 0;
                        else begin
                            if (!b[rr*7+cc]) ok = 0;
                            mm[rr*7+cc] = 1'b1;
                        end
                    end
                    if (ok && !found) begin
                        found = 1;
                        lat   = a + 1;
                        w     = (p == 0) ? 2'b01 : 2'b10;
                        m     = mm;
                    end
                end
            end
        end
        if (!found && ((r | y) == {42{1'b1}})) w = 2'b11;
    endfunction

    // lat = number of edges after the accepting edge until done reads high
    task automatic run_eval(input logic [41:0] r, input logic [41:0] y,
                            input int exp_lat, input logic [1:0] exp_w,
                            input logic [41:0] exp_m, input string tag);
        int lat;
        bit got;
        red    = r;
        yellow = y;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        red    = rand42();
        yellow = rand42();
        lat    = 0;
        got    = 0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) got = 1;
        end
        if (!got) lat = -1;
        check_eq({tag, ".lat"}, lat, exp_lat);
        check_eq({tag, ".winner"}, winner, exp_w);
        check_eq({tag, ".check"}, check_o, exp_w != 2'b00);
        check_eq({tag, ".mask"}, win_mask, mask_exp(exp_m));
        check_eq({tag, ".busy"}, busy, 1'b1);
        @(posedge clk);
        #1;
        check_eq({tag, ".pulse"}, done, 1'b0);
        check_eq({tag, ".idle"}, busy, 1'b0);
        check_eq({tag, ".hold"}, winner, exp_w);
    endtask

    initial begin
        int lat, ndone;
        logic [1:0] w;
        logic [41:0] m, r, y;
        n_checks = 0;
        n_errors = 0;
        reset  = 1'b0;
        start  = 1'b0;
        red    = '0;
        yellow = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.busy", busy, 1'b0);
        check_eq("rst.done", done, 1'b0);
        check_eq("rst.winner", winner, 2'b00);
        check_eq("rst.check", check_o, 1'b0);
        check_eq("rst.mask", win_mask, 42'h0);

        reset = 1'b1;
        run_eval(42'h00F, 42'h0, 1, 2'b01, 42'h00F, "h_red");
        run_eval(42'h0, 42'h204081, 1, 2'b10, 42'h204081, "v_yel");
        run_eval(42'h0F0, 42'h0, 42, 2'b00, 42'h0, "wrap");
        run_eval(42'h208208, 42'h0, 4, 2'b01, 42'h208208, "dl");
        run_eval(42'h1010101, 42'h0, 1, 2'b01, 42'h1010101, "dr");
        run_eval(42'h152A5556AD5, 42'h2AD5AAA952A, 42, 2'b11, 42'h0, "draw");
        run_eval(42'h00F, 42'h00F, 1, 2'b01, 42'h00F, "tie_red");

        // start pulsed mid-scan must be ignored
        red   = 42'h0F0;
        yellow = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        lat   = 0;
        for (int i = 1; i <= 60; i++) begin
            start = (i == 5);
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                lat = i;
            end
        end
        start = 1'b0;
        check_eq("midstart.ndone", ndone, 1);
        check_eq("midstart.lat", lat, 42);

        // held start retriggers every three edges on an anchor-0 hit
        red   = 42'h00F;
        start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        start = 1'b0;
        check_eq("retrig.ndone", ndone, 4);
        lat = 0;
        while (busy && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("retrig.idle", busy, 1'b0);

        // reset in the middle of a no-win scan
        red    = 42'h0F0;
        yellow = '0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort.busy", busy, 1'b0);
        check_eq("abort.done", done, 1'b0);
        check_eq("abort.winner", winner, 2'b00);
        check_eq("abort.check", check_o, 1'b0);
        check_eq("abort.mask", win_mask, 42'h0);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check_eq("abort.ndone", ndone, 0);
        run_eval(42'h0, 42'h41041 << 3, 4, 2'b10, 42'h41041 << 3, "post_rst");

        // randomized boards against the reference model
        for (int t = 0; t < 40; t++) begin
            case (t % 4)
                0: begin
                    r = rand42() & rand42() & rand42();
                    y = rand42() & rand42() & rand42();
                end
                1: begin
                    r = rand42() & rand42();
                    y = ~r & rand42() & rand42();
                end
                2: begin
                    r = rand42();
                    y = ~r;
                end
                default: begin
                    r = rand42() & rand42() & rand42() & rand42();
                    y = rand42() & rand42() & rand42() & rand42();
                end
            endcase
            model(r, y, lat, w, m);
            run_eval(r, y, lat, w, m, $sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/win_checker.md
WIN_CHECKER -- requirements
Module: win_checker

Interface
REQ-001 The block SHALL have exactly one clock domain; reset SHALL be synchronous and active-low, and all outputs SHALL be registered.
REQ-002 Port `clk`  input  1  25 MHz system clock; all state SHALL update on its rising edge.
REQ-003 Port `reset`  input  1  synchronous active-low reset; sampled 0 on a rising edge of `clk` SHALL reset the block.
REQ-004 Port `red_player`  input  42  red occupancy bitboard; bit index = row*7+col, with row 0 = bottom row (0..5) and col 0 = leftmost column (0..6).
REQ-005 Port `yellow_player`  input  42  yellow occupancy bitboard; same indexing as `red_player`.
REQ-006 Port `start`  input  1  request to evaluate the boards; SHALL be honoured only in state IDLE.
REQ-007 Port `busy`  output  1  high in states SCAN and DONE.
REQ-008 Port `done`  output  1  single-cycle pulse marking that `winner` is valid.
REQ-009 Port `winner`  output  2  evaluation result: 00 = none, 01 = red, 10 = yellow, 11 = draw.
REQ-010 Port `check`  output  1  game over; high whenever `winner` != 00.
REQ-011 Port `win_mask`  output  42  the four cells of the winning line (see Configuration).

Function
REQ-012 The FSM SHALL have three states (IDLE, SCAN, DONE) with these transitions:
- IDLE -> SCAN when `start` = 1.
- SCAN -> DONE on a hit or after anchor 41.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 On the IDLE edge that accepts `start`, the block SHALL:
- snapshot both boards into internal registers;
- set the anchor to row 0, col 0 (index 0).
Input changes after this edge SHALL NOT affect the result.
REQ-014 In SCAN, one anchor per cycle SHALL be evaluated against the snapshot, testing four directions for both players:
- H: anchor, +1, +2, +3; valid only when col<=3.
- V: anchor, +7, +14, +21; valid only when row<=2.
- DR: anchor, +8, +16, +24; valid only when col<=3 and row<=2.
- DL: anchor, +6, +12, +18; valid only when col>=3 and row<=2.
REQ-015 Any test whose validity condition is false SHALL be suppressed; there SHALL be no wrap-around from col 6 to col 0 of the next row.
REQ-016 The anchor SHALL be tracked with separate row/col counters, with no divide; col wraps 6->0 with row+1. Index 41 is the last anchor.
REQ-017 Winner priority SHALL be:
- the lowest anchor index wins;
- at the same anchor red beats yellow;
- at the same anchor and player, direction priority is H > V > DR > DL.
REQ-018 On the first hit, SCAN SHALL terminate early. For `start` accepted at edge N and a hit at anchor k, `done` SHALL be high in cycle N+k+2.
REQ-019 With no hit, `done` SHALL be high in cycle N+43.
REQ-020 With no hit and (red|yellow) = all 42 ones, `winner` SHALL be 11; otherwise it SHALL be 00.
REQ-021 Overlapping red/yellow bits SHALL NOT be checked; the boards SHALL be evaluated as given.
REQ-022 `winner`, `check` and `win_mask` SHALL update on the edge entering DONE and SHALL hold until the next DONE or reset.
REQ-023 `start` SHALL be ignored in SCAN and DONE, with no queuing. A `start` in the cycle after DONE (IDLE) SHALL be accepted.
REQ-024 `start` held high SHALL retrigger an evaluation each time the FSM returns to IDLE.

Reset
REQ-025 When `reset` = 0 the block SHALL enter IDLE and clear the following: `busy`=0, `done`=0, `winner`=00, `check`=0, `win_mask`=0, snapshot=0, anchor=0.
REQ-026 A reset asserted mid-SCAN SHALL abort the evaluation with no `done` pulse.
REQ-027 The first `start` SHALL be accepted on the first edge with `reset` = 1.

Configuration
REQ-028 With macro `WIN_MASK_EN` defined, `win_mask` SHALL carry exactly the four bits of the winning line on a red or yellow result, and 0 on none or draw.
REQ-029 Without `WIN_MASK_EN`, `win_mask` SHALL be tied to 0 and its generation logic SHALL be removed; the port SHALL remain and all other behaviour SHALL be identical.

Verification
REQ-030 H win, early exit: red=42'h00F, yellow=0, `start` at edge N -> `done` in cycle N+2, `winner`=01, `check`=1, `win_mask`=42'h00F (with `WIN_MASK_EN`).
REQ-031 V win, yellow: yellow=42'h204081, red=0 -> `done` in cycle N+2, `winner`=10, `win_mask`=42'h204081.
REQ-032 Row-wrap rejection: red=42'h0F0 (bits 4..7) -> `done` in cycle N+43, `winner`=00, `check`=0.
REQ-033 Diagonals:
- red=42'h208208 -> `winner`=01, `done` in cycle N+5 (anchor 3).
- red=42'h1010101 -> `done` in cycle N+2.
REQ-034 Draw: red=42'h152A5556AD5, yellow=42'h2AD5AAA952A -> `done` in cycle N+43, `winner`=11, `check`=1, `win_mask`=0.
REQ-035 Control corners: both checks SHALL hold for this scenario.
- `start` pulsed during SCAN -> ignored, exactly one `done`.
- `reset`=0 at cycle N+10 of a no-win scan -> no `done`, all outputs 0, IDLE on the next cycle.
